sdr_scl_sequencer: RTL and testbench

SDR_SCL_SEQUENCER -- requirements
Module: sdr_scl_sequencer

---
 rtl/sdr_scl_seq_pkg.sv | 30 +++
 rtl/sdr_seq_word_counter.sv | 47 ++++
 rtl/sdr_scl_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sdr_scl_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_scl_seq_pkg.sv
// ----------------------------------------------------------------------------
// sdr_scl_seq_pkg
// Shared definitions for the SDR SCL frame sequencer:
//   - seq_state_e : sequencer state enumeration (ST_STALL exists only when
//                   SDR_SCL_SEQ_STALL_EN is defined)
//   - WORD_BITS   : bits per bus word (8 data bits + ACK slot)
//   - LAST_BIT    : index of the ACK slot within a word
//   - SDA_ACK / SDA_NACK : level of the sampled SDA line in the ACK slot
// Optional feature macro: SDR_SCL_SEQ_STALL_EN
// ----------------------------------------------------------------------------
package sdr_scl_seq_pkg;

    localparam int unsigned WORD_BITS = 9;
    localparam logic [3:0]  LAST_BIT  = 4'(WORD_BITS - 1);

    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
`ifdef SDR_SCL_SEQ_STALL_EN
        ST_STALL = 3'd4,
`endif
        ST_STOP  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sdr_seq_word_counter.sv
// ----------------------------------------------------------------------------
// sdr_seq_word_counter
// Bit index within a 9-bit bus word. Counts 0..8 on each increment strobe and
// wraps back to 0 after the ACK slot.
// Ports:
//   i_sdr_ctrl_clk   : clock
//   i_sdr_ctrl_rst_n : asynchronous active-low reset (count -> 0)
//   clear_i          : force the count to 0 (has priority over inc_i)
//   inc_i            : advance the count by one (wrapping 8 -> 0)
//   bit_cnt_o        : registered bit index
//   last_bit_o       : high while the index sits on the ACK slot (8)
// ----------------------------------------------------------------------------
module sdr_seq_word_counter
    import sdr_scl_seq_pkg::*;
(
    input  logic       i_sdr_ctrl_clk,
    input  logic       i_sdr_ctrl_rst_n,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic [3:0] bit_cnt_o,
    output logic       last_bit_o
);

    logic [3:0] bit_cnt_q;
    logic [3:0] bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clear_i) begin
            bit_cnt_d = '0;
        end else if (inc_i) begin
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? 4'd0 : bit_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt_o  = bit_cnt_q;
    assign last_bit_o = (bit_cnt_q == LAST_BIT);

endmodule

// File: rtl/sdr_scl_sequencer.sv
// ----------------------------------------------------------------------------
// sdr_scl_sequencer
// Frame sequencer driving an SCL generator: START, one open-drain address
// word with ACK check, NUM bytes of push-pull data words, STOP.
// Parameters:
//   NUM_BYTES_W      : width of the byte-count field
// Ports:
//   i_sdr_ctrl_clk   : 50 MHz clock
//   i_sdr_ctrl_rst_n : asynchronous active-low reset
//   i_seq_start      : one-cycle frame request (honoured in IDLE only)
//   i_seq_num_bytes  : data bytes following the address word
//   i_scl_pos_edge   : SCL rising-edge strobe from the generator
//   i_scl_neg_edge   : SCL falling-edge strobe (wins over a coincident rise)
//   i_sda            : sampled SDA, read in the address ACK slot
//   i_stall_req      : upstream data-not-ready
//   o_scl_gen_pp_od  : 1 push-pull, 0 open-drain
//   o_scl_gen_stall  : hold the SCL generator between data bytes
//   o_scl_idle       : SCL generator idle/stop
//   o_timer_cas      : START condition timing request
//   o_bit_cnt        : bit index 0..8 within the current word
//   o_busy, o_done, o_nack : status (o_done is a one-cycle pulse)
// Optional feature macro: SDR_SCL_SEQ_STALL_EN (enables the STALL state)
// ----------------------------------------------------------------------------
module sdr_scl_sequencer
    import sdr_scl_seq_pkg::*;
#(
    parameter int NUM_BYTES_W = 8
) (
    input  logic                   i_sdr_ctrl_clk,
    input  logic                   i_sdr_ctrl_rst_n,
    input  logic                   i_seq_start,
    input  logic [NUM_BYTES_W-1:0] i_seq_num_bytes,
    input  logic                   i_scl_pos_edge,
    input  logic                   i_scl_neg_edge,
    input  logic                   i_sda,
    input  logic                   i_stall_req,
    output logic                   o_scl_gen_pp_od,
    output logic                   o_scl_gen_stall,
    output logic                   o_scl_idle,
    output logic                   o_timer_cas,
    output logic [3:0]             o_bit_cnt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_nack
);

    seq_state_e             state_q;
    logic [NUM_BYTES_W-1:0] byte_cnt_q;
    logic                   sda_sample_q;
    logic                   pp_od_q;
    logic                   scl_idle_q;
    logic                   timer_cas_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   nack_q;

    // A rise coincident with a fall is dropped; the fall alone is acted on.
    logic neg_edge;
    logic pos_edge;
    assign neg_edge = i_scl_neg_edge;
    assign pos_edge = i_scl_pos_edge & ~i_scl_neg_edge;

    logic       cnt_clear;
    logic       cnt_inc;
    logic       bit_last;
    logic [3:0] bit_cnt;

    assign cnt_clear = (state_q == ST_IDLE) && i_seq_start;
    assign cnt_inc   = neg_edge && ((state_q == ST_ADDR) || (state_q == ST_DATA));

    // The counter wraps 8 -> 0 on the word-closing fall, so every new word
    // (address -> data, data -> data, stall -> data) starts at index 0.
    sdr_seq_word_counter u_word_counter (
        .i_sdr_ctrl_clk   (i_sdr_ctrl_clk),
        .i_sdr_ctrl_rst_n (i_sdr_ctrl_rst_n),
        .clear_i          (cnt_clear),
        .inc_i            (cnt_inc),
        .bit_cnt_o        (bit_cnt),
        .last_bit_o       (bit_last)
    );

`ifdef SDR_SCL_SEQ_STALL_EN
    logic stall_q;
`else
    logic stall_req_unused;
    assign stall_req_unused = i_stall_req;
`endif

    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            sda_sample_q <= SDA_ACK;
            pp_od_q      <= 1'b0;
            scl_idle_q   <= 1'b1;
            timer_cas_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nack_q       <= 1'b0;
`ifdef SDR_SCL_SEQ_STALL_EN
            stall_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_seq_start) begin
                        byte_cnt_q   <= i_seq_num_bytes;
                        sda_sample_q <= SDA_ACK;
                        nack_q       <= 1'b0;
                        timer_cas_q  <= 1'b1;
                        scl_idle_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_START;
                    end
                end

                ST_START: begin
                    if (neg_edge) begin
                        timer_cas_q <= 1'b0;
                        state_q     <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (neg_edge) begin
                        if (bit_last) begin
                            if (sda_sample_q == SDA_NACK) begin
                                nack_q     <= 1'b1;
                                scl_idle_q <= 1'b1;
                                state_q    <= ST_STOP;
                            end else if (byte_cnt_q == '0) begin
                                scl_idle_q <= 1'b1;
                                state_q    <= ST_STOP;
                            end else begin
                                pp_od_q <= 1'b1;
                                state_q <= ST_DATA;
                            end
                        end
                    end else if (pos_edge && bit_last) begin
                        sda_sample_q <= i_sda;
                    end
                end

                ST_DATA: begin
                    // byte_cnt_q is at least 1 here, so the decrement cannot wrap.
                    if (neg_edge && bit_last) begin
                        byte_cnt_q <= byte_cnt_q - NUM_BYTES_W'(1);
                        if (byte_cnt_q == NUM_BYTES_W'(1)) begin
                            pp_od_q    <= 1'b0;
                            scl_idle_q <= 1'b1;
                            state_q    <= ST_STOP;
                        end
`ifdef SDR_SCL_SEQ_STALL_EN
                        else if (i_stall_req) begin
                            stall_q <= 1'b1;
                            state_q <= ST_STALL;
                        end
`endif
                    end
                end

`ifdef SDR_SCL_SEQ_STALL_EN
                ST_STALL: begin
                    if (!i_stall_req) begin
                        stall_q <= 1'b0;
                        state_q <= ST_DATA;
                    end
                end
`endif

                ST_STOP: begin
                    if (pos_edge) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    pp_od_q     <= 1'b0;
                    scl_idle_q  <= 1'b1;
                    timer_cas_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_scl_gen_pp_od = pp_od_q;
    assign o_scl_idle      = scl_idle_q;
    assign o_timer_cas     = timer_cas_q;
    assign o_bit_cnt       = bit_cnt;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_nack          = nack_q;
`ifdef SDR_SCL_SEQ_STALL_EN
    assign o_scl_gen_stall = stall_q;
`else
    assign o_scl_gen_stall = 1'b0;
`endif

endmodule

// File: tb/tb_sdr_scl_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sdr_scl_sequencer
// Self-checking bench for sdr_scl_sequencer. A frame is described by its
// byte count and ACK/NACK; the expected outputs after the k-th SCL fall of a
// frame are computed arithmetically from that description.
// Honours SDR_SCL_SEQ_STALL_EN for the stall expectations.
// ----------------------------------------------------------------------------
module tb_sdr_scl_sequencer;

    localparam int NBW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           seq_start = 1'b0;
    logic [NBW-1:0] seq_num_bytes = '0;
    logic           scl_pos = 1'b0;
    logic           scl_neg = 1'b0;
    logic           sda = 1'b0;
    logic           stall_req = 1'b0;
    logic           pp_od, gen_stall, scl_idle, timer_cas, busy, done, nack;
    logic [3:0]     bit_cnt;

    int tests = 0;
    int fails = 0;

`ifdef SDR_SCL_SEQ_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    sdr_scl_sequencer #(.NUM_BYTES_W(NBW)) dut (
        .i_sdr_ctrl_clk   (clk),
        .i_sdr_ctrl_rst_n (rst_n),
        .i_seq_start      (seq_start),
        .i_seq_num_bytes  (seq_num_bytes),
        .i_scl_pos_edge   (scl_pos),
        .i_scl_neg_edge   (scl_neg),
        .i_sda            (sda),
        .i_stall_req      (stall_req),
        .o_scl_gen_pp_od  (pp_od),
        .o_scl_gen_stall  (gen_stall),
        .o_scl_idle       (scl_idle),
        .o_timer_cas      (timer_cas),
        .o_bit_cnt        (bit_cnt),
        .o_busy           (busy),
        .o_done           (done),
        .o_nack           (nack)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gap(input int gap_max);
        int n;
        n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (n) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_idle"},   scl_idle,  1);
        check({tag, "_pp"},     pp_od,     0);
        check({tag, "_stall"},  gen_stall, 0);
        check({tag, "_cas"},    timer_cas, 0);
        check({tag, "_bitcnt"}, bit_cnt,   0);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_done"},   done,      0);
        check({tag, "_nack"},   nack,      0);
    endtask

    // nb: data bytes; nack_bit: level driven in the address ACK slot.
    // coin: drive the address-closing fall together with a rise carrying the
    //       opposite SDA level (the rise must be ignored).
    // start_k: after fall k, pulse a stray start request (-1 = none).
    // stall_cycles: hold stall_req across the fall closing data byte 1.
    // abort_k: assert reset mid-cycle after fall k (-1 = none).
    task automatic run_frame(input int nb, input bit nack_bit, input int gap_max,
                             input bit coin, input int start_k,
                             input int stall_cycles, input int abort_k);
        int  last;
        bit  data_phase;
        bit  exp_stall;
        $display("[TB] frame nb=%0d nack=%0d gap=%0d coin=%0d start_k=%0d stall=%0d abort_k=%0d",
                 nb, nack_bit, gap_max, coin, start_k, stall_cycles, abort_k);
        data_phase = !nack_bit && (nb > 0);
        last       = data_phase ? 9 + 9 * nb : 9;

        seq_num_bytes = NBW'(nb);
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        seq_num_bytes = NBW'($urandom);
        check("start_busy",   busy,      1);
        check("start_cas",    timer_cas, 1);
        check("start_idle",   scl_idle,  0);
        check("start_pp",     pp_od,     0);
        check("start_bitcnt", bit_cnt,   0);
        check("start_nack",   nack,      0);
        gap(gap_max);

        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                sda = (k == 9) ? nack_bit : 1'($urandom);
                scl_pos = 1'b1;
                step();
                scl_pos = 1'b0;
                gap(gap_max);
            end
            if (k == 9 && coin) begin
                sda = ~nack_bit;
                scl_pos = 1'b1;
            end
            exp_stall = 1'b0;
            if (k == 18 && stall_cycles > 0) begin
                stall_req = 1'b1;
                exp_stall = STALL_EN && (k < last);
            end
            scl_neg = 1'b1;
            step();
            scl_neg = 1'b0;
            scl_pos = 1'b0;

            check("edge_bitcnt", bit_cnt, k % 9);
            check("edge_pp",     pp_od,   data_phase && k >= 9 && k < last);
            check("edge_idle",   scl_idle, k >= last);
            check("edge_busy",   busy,    1);
            check("edge_cas",    timer_cas, 0);
            check("edge_nack",   nack,    nack_bit && k >= 9);
            check("edge_done",   done,    0);

            if (k == 18 && stall_cycles > 0) begin
                for (int c = 0; c < stall_cycles; c++) begin
                    check("stall_on", gen_stall, exp_stall);
                    step();
                end
                stall_req = 1'b0;
                step();
                check("stall_off",    gen_stall, 0);
                check("stall_bitcnt", bit_cnt,   0);
            end else begin
                check("no_stall", gen_stall, 0);
            end

            if (k == start_k) begin
                seq_num_bytes = NBW'($urandom_range(5, 200));
                seq_start = 1'b1;
                step();
                seq_start = 1'b0;
                check("stray_start_busy",   busy,      1);
                check("stray_start_cas",    timer_cas, 0);
                check("stray_start_bitcnt", bit_cnt,   k % 9);
            end

            if (k == abort_k) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_reset_values("abort");
                step();
                step();
                rst_n = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    step();
                    check("abort_no_done", done, 0);
                    check("abort_busy",    busy, 0);
                end
                return;
            end
            gap(gap_max);
        end

        scl_pos = 1'b1;
        step();
        scl_pos = 1'b0;
        check("stop_done", done,     1);
        check("stop_busy", busy,     0);
        check("stop_idle", scl_idle, 1);
        check("stop_pp",   pp_od,    0);
        check("stop_nack", nack,     nack_bit);
        step();
        check("done_pulse", done, 0);
        check("idle_busy",  busy, 0);
        check("idle_nack",  nack, nack_bit);
        gap(gap_max);
    endtask

    initial begin
        step();
        check_reset_values("in_reset");
        step();
        rst_n = 1'b1;
        step();
        check_reset_values("post_reset");

        run_frame(2, 1'b0, 2, 1'b0, -1, 0, -1);    // two bytes, ACK
        run_frame(3, 1'b1, 1, 1'b0, -1, 0, -1);    // NACK on address
        run_frame(0, 1'b0, 1, 1'b0, -1, 0, -1);    // address only
        run_frame(3, 1'b0, 1, 1'b0, -1, 20, -1);   // stall after byte 1
        run_frame(1, 1'b0, 1, 1'b0, -1, 20, -1);   // stall request on final byte
        run_frame(3, 1'b0, 1, 1'b0, -1, 0, 13);    // reset at data bit 4
        run_frame(1, 1'b0, 1, 1'b0, -1, 0, -1);    // new frame after abort
        run_frame(1, 1'b0, 1, 1'b1, 4, 0, -1);     // stray start + coincident edges
        run_frame(0, 1'b1, 1, 1'b1, 2, 0, -1);     // coincident edges, NACK case

        for (int i = 0; i < 8; i++) begin
            run_frame(int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
                      2, 1'($urandom), int'($urandom_range(1, 8)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0, -1);
        end

        run_frame(255, 1'b0, 0, 1'b0, -1, 0, -1);  // maximum byte count

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
